// File: rtl/orion_types.sv
// Shared core types: datapath widths and the write-back entry payload.
package orion_types;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RF_IDX_BITS = 5;
  localparam int unsigned NUM_REGS    = 32;

  // One register-file write: destination index plus value.
  typedef struct packed {
    logic [RF_IDX_BITS-1:0] rd;
    logic [XLEN-1:0]        v;
  } wb_entry_t;

endpackage : orion_types

// File: rtl/wb_fifo.sv
// Single-clock FIFO for long-latency write-back results.
module wb_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule : wb_fifo

// File: rtl/rf_writeback.sv
// Register-file write port arbiter (ALU over buffered LSU/MUL results)
// with a per-register pending scoreboard for decode operand stalls.
module rf_writeback
  import orion_types::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   iss_valid_i,
  input  logic [RF_IDX_BITS-1:0] iss_rd_i,
  input  logic                   alu_valid_i,
  input  logic [RF_IDX_BITS-1:0] alu_rd_i,
  input  logic [XLEN-1:0]        alu_v_i,
  input  logic                   lsu_valid_i,
  output logic                   lsu_ready_o,
  input  logic [RF_IDX_BITS-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]        lsu_v_i,
  output logic                   rf_we_o,
  output logic [RF_IDX_BITS-1:0] rf_rd_s_o,
  output logic [XLEN-1:0]        rf_rd_v_o,
  input  logic [RF_IDX_BITS-1:0] rs1_s_i,
  input  logic [RF_IDX_BITS-1:0] rs2_s_i,
  output logic                   rs1_busy_o,
  output logic                   rs2_busy_o
);

  wb_entry_t           lsu_entry;
  wb_entry_t           alu_entry;
  wb_entry_t           head;
  wb_entry_t           out_q;
  wb_entry_t           out_d;
  logic                we_q;
  logic                we_d;
  logic                from_lsu_q;
  logic                from_lsu_d;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                alu_take;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  assign lsu_entry = '{rd: lsu_rd_i, v: lsu_v_i};
  assign alu_entry = '{rd: alu_rd_i, v: alu_v_i};

  assign lsu_ready_o = !fifo_full && !rst_i;
  assign push        = lsu_valid_i && lsu_ready_o;

  wb_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (wb_entry_t)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (lsu_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ALU wins the port; x0 ALU results are dropped and leave the slot to the FIFO.
  always_comb begin
    we_d       = 1'b0;
    from_lsu_d = 1'b0;
    out_d      = out_q;
    alu_take   = alu_valid_i && (alu_rd_i != '0);
    pop        = !alu_take && !fifo_empty;
    if (alu_take) begin
      we_d  = 1'b1;
      out_d = alu_entry;
    end else if (pop && (head.rd != '0)) begin
      we_d       = 1'b1;
      from_lsu_d = 1'b1;
      out_d      = head;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q       <= 1'b0;
      from_lsu_q <= 1'b0;
      out_q      <= '0;
    end else begin
      we_q       <= we_d;
      from_lsu_q <= from_lsu_d;
      out_q      <= out_d;
    end
  end

  assign rf_we_o   = we_q;
  assign rf_rd_s_o = out_q.rd;
  assign rf_rd_v_o = out_q.v;

  // Clear on the edge the register file captures the value; a same-index issue wins.
  always_comb begin
    pending_d = pending_q;
    if (we_q && from_lsu_q) begin
      pending_d[out_q.rd] = 1'b0;
    end
    if (iss_valid_i && (iss_rd_i != '0)) begin
      pending_d[iss_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_busy_o = (rs1_s_i != '0) && pending_q[rs1_s_i];
  assign rs2_busy_o = (rs2_s_i != '0) && pending_q[rs2_s_i];

endmodule : rf_writeback
